// File: rtl/rtc_calendar_core_pkg.sv
// Shared types, field limits and month-length helper for the RTC calendar core.
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_SET_HOUR  = 3'd1,
      ST_SET_MIN   = 3'd2,
      ST_SET_DAY   = 3'd3,
      ST_SET_MONTH = 3'd4,
      ST_SET_YEAR  = 3'd5
   } state_t;

   localparam logic [5:0] SEC_MAX   = 6'd59;
   localparam logic [5:0] MIN_MAX   = 6'd59;
   localparam logic [4:0] HOUR_MAX  = 5'd23;
   localparam logic [3:0] MONTH_MAX = 4'd12;
   localparam logic [6:0] YEAR_MAX  = 7'd99;

   // Every year divisible by four is a leap year inside 2000-2099.
   function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [6:0] year);
      case (month)
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         4'd2:                    return (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 return 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// Control inputs and field/strobe outputs of the RTC calendar core.
interface rtc_calendar_core_if;
   logic       run;
   logic       key_mode;
   logic       key_inc;
   logic [5:0] second;
   logic [5:0] minute;
   logic [4:0] hour;
   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;
   logic [2:0] set_state;
   logic       sec_pulse;
   logic       day_pulse;
   logic       blink;

   modport master (
      output run, key_mode, key_inc,
      input  second, minute, hour, day, month, year, set_state, sec_pulse, day_pulse, blink
   );

   modport slave (
      input  run, key_mode, key_inc,
      output second, minute, hour, day, month, year, set_state, sec_pulse, day_pulse, blink
   );
endinterface

// File: rtl/rtc_calendar_core_debounce.sv
// Key synchroniser and debouncer; emits a one-cycle press on the debounced rising edge.
module key_debounce #(
   parameter int DEB_PERIOD    = 1024,
   parameter int DEB_SAMPLES   = 4,
   parameter bit EXT_SAMPLE_EN = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   input  logic sample_en,
   output logic key_level,
   output logic key_press
);
   logic [1:0]             r_sync;
   logic [DEB_SAMPLES-1:0] r_shift;
   logic                   r_level;
   logic                   r_press;
   logic                   w_sampleEn;
   logic [DEB_SAMPLES-1:0] w_shiftNext;

   // A shared sample strobe may come from outside so several keys need only one counter.
   generate
      if (EXT_SAMPLE_EN) begin : g_extEn
         assign w_sampleEn = sample_en;
      end else begin : g_intEn
         localparam int CNT_W = (DEB_PERIOD > 1) ? $clog2(DEB_PERIOD) : 1;
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_PERIOD - 1);
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) r_cnt <= '0;
            else       r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         end
         assign w_sampleEn = (r_cnt == CNT_LAST);
      end
   endgenerate

   assign w_shiftNext = DEB_SAMPLES'({r_shift, r_sync[1]});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_shift <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], key_raw};
         r_press <= 1'b0;
         if (w_sampleEn) begin
            r_shift <= w_shiftNext;
            if (&w_shiftNext) begin
               r_level <= 1'b1;
               r_press <= ~r_level;
            end else if (~|w_shiftNext) begin
               r_level <= 1'b0;
            end
         end
      end
   end

   assign key_level = r_level;
   assign key_press = r_press;
endmodule

// File: rtl/rtc_calendar_core.sv
// Time-of-day and 2000-2099 calendar counter with a run gate and a two-key set mode.
module rtc_calendar_core
   import rtc_pkg::*;
#(
   parameter int CLK_PER_SEC = 65536,
   parameter int DEB_PERIOD  = 1024,
   parameter int DEB_SAMPLES = 4
) (
   input logic          clock,
   input logic          reset,
   rtc_calendar_core_if.slave bus
);
   localparam int PRE_W = $clog2(CLK_PER_SEC);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
   localparam int DEB_W = (DEB_PERIOD > 1) ? $clog2(DEB_PERIOD) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_PERIOD - 1);

   state_t           r_state, w_nextState;
   logic [PRE_W-1:0] r_presc;
   logic [DEB_W-1:0] r_debCnt;
   logic [5:0]       r_second, r_minute;
   logic [4:0]       r_hour, r_day;
   logic [3:0]       r_month;
   logic [6:0]       r_year;
   logic             r_secPulse, r_dayPulse;

   logic       w_sampleEn, w_modePress, w_incPress, w_unusedModeLevel, w_unusedIncLevel;
   logic       w_count, w_tick, w_incAct, w_exitSet;
   logic [3:0] w_monthNext;
   logic [6:0] w_yearNext;
   logic [4:0] w_dim, w_dimMonthNext, w_dimYearNext;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_debCnt <= '0;
      else       r_debCnt <= (r_debCnt == DEB_LAST) ? '0 : r_debCnt + 1'b1;
   end
   assign w_sampleEn = (r_debCnt == DEB_LAST);

   key_debounce #(.DEB_PERIOD(DEB_PERIOD), .DEB_SAMPLES(DEB_SAMPLES), .EXT_SAMPLE_EN(1'b1)) u_keyMode (
      .clock(clock), .reset(reset), .key_raw(bus.key_mode), .sample_en(w_sampleEn),
      .key_level(w_unusedModeLevel), .key_press(w_modePress));

   key_debounce #(.DEB_PERIOD(DEB_PERIOD), .DEB_SAMPLES(DEB_SAMPLES), .EXT_SAMPLE_EN(1'b1)) u_keyInc (
      .clock(clock), .reset(reset), .key_raw(bus.key_inc), .sample_en(w_sampleEn),
      .key_level(w_unusedIncLevel), .key_press(w_incPress));

   assign w_count        = (r_state == ST_RUN) && bus.run;
   assign w_tick         = w_count && (r_presc == PRE_LAST);
   assign w_incAct       = w_incPress && !w_modePress;
   assign w_exitSet      = (r_state == ST_SET_YEAR) && w_modePress;
   assign w_monthNext    = (r_month == MONTH_MAX) ? 4'd1 : r_month + 4'd1;
   assign w_yearNext     = (r_year == YEAR_MAX) ? 7'd0 : r_year + 7'd1;
   assign w_dim          = days_in_month(r_month, r_year);
   assign w_dimMonthNext = days_in_month(w_monthNext, r_year);
   assign w_dimYearNext  = days_in_month(r_month, w_yearNext);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_nextState;
   end

   // Undefined encodings fall back to RUN even without a key press.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_RUN:       if (w_modePress) w_nextState = ST_SET_HOUR;
         ST_SET_HOUR:  if (w_modePress) w_nextState = ST_SET_MIN;
         ST_SET_MIN:   if (w_modePress) w_nextState = ST_SET_DAY;
         ST_SET_DAY:   if (w_modePress) w_nextState = ST_SET_MONTH;
         ST_SET_MONTH: if (w_modePress) w_nextState = ST_SET_YEAR;
         ST_SET_YEAR:  if (w_modePress) w_nextState = ST_RUN;
         default:      w_nextState = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)          r_presc <= '0;
      else if (w_exitSet) r_presc <= '0;
      else if (w_count)   r_presc <= w_tick ? '0 : r_presc + 1'b1;
   end

   // Ticks only happen in RUN and increments only in SET states, so the branches never collide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_second   <= '0;
         r_minute   <= '0;
         r_hour     <= '0;
         r_day      <= 5'd1;
         r_month    <= 4'd1;
         r_year     <= '0;
         r_secPulse <= 1'b0;
         r_dayPulse <= 1'b0;
      end else begin
         r_secPulse <= 1'b0;
         r_dayPulse <= 1'b0;
         if (w_exitSet) begin
            r_second <= '0;
         end else if (w_tick) begin
            r_secPulse <= 1'b1;
            if (r_second != SEC_MAX) r_second <= r_second + 6'd1;
            else begin
               r_second <= '0;
               if (r_minute != MIN_MAX) r_minute <= r_minute + 6'd1;
               else begin
                  r_minute <= '0;
                  if (r_hour != HOUR_MAX) r_hour <= r_hour + 5'd1;
                  else begin
                     r_hour     <= '0;
                     r_dayPulse <= 1'b1;
                     if (r_day != w_dim) r_day <= r_day + 5'd1;
                     else begin
                        r_day   <= 5'd1;
                        r_month <= w_monthNext;
                        if (r_month == MONTH_MAX) r_year <= w_yearNext;
                     end
                  end
               end
            end
         end else if (w_incAct) begin
            case (r_state)
               ST_SET_HOUR: r_hour   <= (r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
               ST_SET_MIN:  r_minute <= (r_minute == MIN_MAX) ? 6'd0 : r_minute + 6'd1;
               ST_SET_DAY:  r_day    <= (r_day >= w_dim) ? 5'd1 : r_day + 5'd1;
               ST_SET_MONTH: begin
                  r_month <= w_monthNext;
                  if (r_day > w_dimMonthNext) r_day <= w_dimMonthNext;
               end
               ST_SET_YEAR: begin
                  r_year <= w_yearNext;
                  if (r_day > w_dimYearNext) r_day <= w_dimYearNext;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.second    = r_second;
   assign bus.minute    = r_minute;
   assign bus.hour      = r_hour;
   assign bus.day       = r_day;
   assign bus.month     = r_month;
   assign bus.year      = r_year;
   assign bus.set_state = r_state;
   assign bus.sec_pulse = r_secPulse;
   assign bus.day_pulse = r_dayPulse;
   assign bus.blink     = (r_state != ST_RUN) && r_presc[PRE_W-1];
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core with a 4-cycle second and fast debounce.
module tb_rtc_calendar_core;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   secPulseCnt = 0;
   int   dayPulseCnt = 0;

   rtc_calendar_core_if bus();

   rtc_calendar_core #(.CLK_PER_SEC(4), .DEB_PERIOD(2), .DEB_SAMPLES(4)) dut (
      .clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #2;
      if (bus.sec_pulse) secPulseCnt++;
      if (bus.day_pulse) dayPulseCnt++;
   end

   // One debounced press: held long enough for four equal samples, then fully released.
   task automatic applyStimulus(input logic modeKey, input logic incKey);
      @(negedge clock);
      bus.key_mode = modeKey;
      bus.key_inc  = incKey;
      repeat (14) @(negedge clock);
      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
      repeat (14) @(negedge clock);
   endtask

   task automatic waitSecPulses(input int n, input string name);
      int target = secPulseCnt + n;
      int budget = n * 4 + 20;
      while (secPulseCnt < target && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      checks++;
      if (secPulseCnt < target) begin failures++; $display("[TB] FAIL %s: sec_pulse count %0d required %0d", name, secPulseCnt, target); end
   endtask

   task automatic test_reset;
      int cycles = 0;
      bus.run = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if ({bus.hour, bus.minute, bus.second} !== 17'd0) begin failures++; $display("[TB] FAIL reset_time: got %0d:%0d:%0d required 0:0:0", bus.hour, bus.minute, bus.second); end
      checks++; if ({bus.day, bus.month, bus.year} !== {5'd1, 4'd1, 7'd0}) begin failures++; $display("[TB] FAIL reset_date: got %0d/%0d/%0d required 1/1/0", bus.day, bus.month, bus.year); end
      checks++; if ({bus.set_state, bus.sec_pulse, bus.day_pulse, bus.blink} !== 6'd0) begin failures++; $display("[TB] FAIL reset_ctrl: got state %0d pulses %b%b blink %b required 0 00 0", bus.set_state, bus.sec_pulse, bus.day_pulse, bus.blink); end
      reset = 1'b0;
      while (cycles < 20) begin
         @(posedge clock);
         #1;
         cycles++;
         if (bus.sec_pulse) break;
      end
      checks++; if (cycles !== 4) begin failures++; $display("[TB] FAIL first_sec_pulse: got %0d cycles required 4", cycles); end
      checks++; if (bus.second !== 6'd1) begin failures++; $display("[TB] FAIL first_second: got %0d required 1", bus.second); end
      @(negedge clock);
      bus.run = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_set_hour;
      int startSec = secPulseCnt;
      applyStimulus(1'b1, 1'b0);
      checks++; if (bus.set_state !== 3'd1) begin failures++; $display("[TB] FAIL enter_set_hour: got %0d required 1", bus.set_state); end
      repeat (3) applyStimulus(1'b0, 1'b1);
      checks++; if ({bus.hour, bus.minute, bus.second} !== {5'd3, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL set_hour3: got %0d:%0d:%0d required 3:0:0", bus.hour, bus.minute, bus.second); end
      checks++; if (secPulseCnt !== startSec) begin failures++; $display("[TB] FAIL set_no_sec_pulse: got %0d pulses required 0", secPulseCnt - startSec); end
      repeat (20) applyStimulus(1'b0, 1'b1);
      checks++; if (bus.hour !== 5'd23) begin failures++; $display("[TB] FAIL set_hour23: got %0d required 23", bus.hour); end
      applyStimulus(1'b0, 1'b1);
      checks++; if ({bus.hour, bus.day} !== {5'd0, 5'd1}) begin failures++; $display("[TB] FAIL hour_wrap: got hour %0d day %0d required hour 0 day 1", bus.hour, bus.day); end
   endtask

   task automatic test_day_clamp;
      repeat (3) applyStimulus(1'b1, 1'b0);
      checks++; if (bus.set_state !== 3'd4) begin failures++; $display("[TB] FAIL enter_set_month: got %0d required 4", bus.set_state); end
      repeat (2) applyStimulus(1'b0, 1'b1);
      checks++; if (bus.month !== 4'd3) begin failures++; $display("[TB] FAIL set_month3: got %0d required 3", bus.month); end
      repeat (5) applyStimulus(1'b1, 1'b0);
      repeat (30) applyStimulus(1'b0, 1'b1);
      checks++; if ({bus.set_state, bus.day} !== {3'd3, 5'd31}) begin failures++; $display("[TB] FAIL set_day31: got state %0d day %0d required state 3 day 31", bus.set_state, bus.day); end
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checks++; if ({bus.month, bus.day} !== {4'd4, 5'd30}) begin failures++; $display("[TB] FAIL day_clamp: got month %0d day %0d required month 4 day 30", bus.month, bus.day); end
      repeat (2) applyStimulus(1'b1, 1'b0);
      checks++; if ({bus.set_state, bus.second} !== {3'd0, 6'd0}) begin failures++; $display("[TB] FAIL return_run: got state %0d second %0d required 0 0", bus.set_state, bus.second); end
   endtask

   task automatic test_leap_year;
      int startDay;
      applyStimulus(1'b1, 1'b0); repeat (23) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (59) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (28) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (10) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (24) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      checks++; if ({bus.set_state, bus.hour, bus.minute, bus.second} !== {3'd0, 5'd23, 6'd59, 6'd0}) begin failures++; $display("[TB] FAIL leap_preload_time: got state %0d %0d:%0d:%0d required 0 23:59:0", bus.set_state, bus.hour, bus.minute, bus.second); end
      checks++; if ({bus.day, bus.month, bus.year} !== {5'd28, 4'd2, 7'd24}) begin failures++; $display("[TB] FAIL leap_preload_date: got %0d/%0d/%0d required 28/2/24", bus.day, bus.month, bus.year); end
      startDay = dayPulseCnt;
      bus.run = 1'b1;
      waitSecPulses(59, "leap_run59");
      checks++; if ({bus.second, bus.day} !== {6'd59, 5'd28} || dayPulseCnt !== startDay) begin failures++; $display("[TB] FAIL leap_2359: got second %0d day %0d day_pulses %0d required 59 28 0", bus.second, bus.day, dayPulseCnt - startDay); end
      waitSecPulses(1, "leap_tick");
      bus.run = 1'b0;
      checks++; if ({bus.day, bus.month, bus.day_pulse} !== {5'd29, 4'd2, 1'b1}) begin failures++; $display("[TB] FAIL leap_feb29: got day %0d month %0d day_pulse %b required 29 2 1", bus.day, bus.month, bus.day_pulse); end
      checks++; if ({bus.hour, bus.minute, bus.second} !== 17'd0) begin failures++; $display("[TB] FAIL leap_midnight: got %0d:%0d:%0d required 0:0:0", bus.hour, bus.minute, bus.second); end
      // Year 24 -> 23 wraps through 99 and clamps day 29 down to 28 on the first non-leap year.
      applyStimulus(1'b1, 1'b0); repeat (23) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (59) applyStimulus(1'b0, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0); repeat (99) applyStimulus(1'b0, 1'b1);
      checks++; if ({bus.set_state, bus.day, bus.year} !== {3'd5, 5'd28, 7'd23}) begin failures++; $display("[TB] FAIL year_clamp: got state %0d day %0d year %0d required 5 28 23", bus.set_state, bus.day, bus.year); end
      applyStimulus(1'b1, 1'b0);
      bus.run = 1'b1;
      waitSecPulses(60, "nonleap_run60");
      bus.run = 1'b0;
      checks++; if ({bus.day, bus.month, bus.year, bus.day_pulse} !== {5'd1, 4'd3, 7'd23, 1'b1}) begin failures++; $display("[TB] FAIL nonleap_mar1: got %0d/%0d/%0d day_pulse %b required 1/3/23 1", bus.day, bus.month, bus.year, bus.day_pulse); end
   endtask

   task automatic test_century_wrap;
      applyStimulus(1'b1, 1'b0); repeat (23) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (59) applyStimulus(1'b0, 1'b1);
      repeat (2) applyStimulus(1'b1, 1'b0); repeat (9) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0); repeat (76) applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b1, 1'b0); repeat (30) applyStimulus(1'b0, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0);
      checks++; if ({bus.set_state, bus.day, bus.month, bus.year} !== {3'd0, 5'd31, 4'd12, 7'd99}) begin failures++; $display("[TB] FAIL century_preload: got state %0d %0d/%0d/%0d required 0 31/12/99", bus.set_state, bus.day, bus.month, bus.year); end
      bus.run = 1'b1;
      waitSecPulses(60, "century_run60");
      bus.run = 1'b0;
      checks++; if ({bus.hour, bus.minute, bus.second} !== 17'd0) begin failures++; $display("[TB] FAIL century_time: got %0d:%0d:%0d required 0:0:0", bus.hour, bus.minute, bus.second); end
      checks++; if ({bus.day, bus.month, bus.year} !== {5'd1, 4'd1, 7'd0}) begin failures++; $display("[TB] FAIL century_date: got %0d/%0d/%0d required 1/1/0", bus.day, bus.month, bus.year); end
   endtask

   task automatic test_debounce;
      bus.run = 1'b1;
      waitSecPulses(2, "deb_run2");
      repeat (2) @(negedge clock);
      bus.run = 1'b0;
      checks++; if ({bus.second, bus.blink} !== {6'd2, 1'b0}) begin failures++; $display("[TB] FAIL hold_run: got second %0d blink %b required 2 0", bus.second, bus.blink); end
      applyStimulus(1'b1, 1'b0);
      checks++; if ({bus.set_state, bus.blink} !== {3'd1, 1'b1}) begin failures++; $display("[TB] FAIL set_blink: got state %0d blink %b required 1 1", bus.set_state, bus.blink); end
      @(negedge clock);
      bus.key_inc = 1'b1;
      repeat (4) @(negedge clock);
      bus.key_inc = 1'b0;
      repeat (20) @(negedge clock);
      checks++; if (bus.hour !== 5'd0) begin failures++; $display("[TB] FAIL short_glitch: got hour %0d required 0", bus.hour); end
      applyStimulus(1'b1, 1'b1);
      checks++; if ({bus.set_state, bus.hour, bus.minute} !== {3'd2, 5'd0, 6'd0}) begin failures++; $display("[TB] FAIL mode_wins: got state %0d hour %0d minute %0d required 2 0 0", bus.set_state, bus.hour, bus.minute); end
      repeat (4) applyStimulus(1'b1, 1'b0);
      checks++; if ({bus.set_state, bus.second} !== {3'd0, 6'd0}) begin failures++; $display("[TB] FAIL exit_clears_second: got state %0d second %0d required 0 0", bus.set_state, bus.second); end
   endtask

   initial begin
      reset = 1'b1;
      bus.run = 1'b0;
      bus.key_mode = 1'b0;
      bus.key_inc = 1'b0;
      test_reset();
      test_set_hour();
      test_day_clamp();
      test_leap_year();
      test_century_wrap();
      test_debounce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
